serial_adder_ctrl: RTL and testbench

//   Bit-serial adder controller. It sequences one FULLADDER bit-slice to add two

---
 rtl/serial_adder_ctrl.sv | 101 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder slice sequenced LSB-first over WIDTH clocks,
// with a start/busy/done handshake and a result held until the next accepted start.

module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic             c_q;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_carry;

    fulladder u_fa (
        .a     (sh_a[0]),
        .b     (sh_b[0]),
        .cin   (c_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sh_a  <= '0;
            sh_b  <= '0;
            c_q   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            carry <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= b;
                        c_q   <= cin;
                        cnt   <= '0;
                        sum   <= '0;
                        carry <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Slice sum enters at the MSB so after WIDTH shifts bit 0 lands at sum[0].
                    sh_a <= sh_a >> 1;
                    sh_b <= sh_b >> 1;
                    c_q  <= fa_carry;
                    sum  <= {fa_sum, sum[WIDTH-1:1]};
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        carry <= fa_carry;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: WIDTH=8 and WIDTH=16 instances, expected
// {carry,sum} = a+b+cin pushed at each modelled acceptance, popped on every done pulse.
module tb_serial_adder_ctrl;
    typedef struct {
        logic [64:0]     val;
        longint unsigned due;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start8 = 1'b0, cin8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, carry8;
    logic [7:0]  sum8;

    logic        start16 = 1'b0, cin16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, carry16;
    logic [15:0] sum16;

    int tests = 0;
    int fails = 0;

    exp_t            q8[$];
    exp_t            q16[$];
    longint unsigned cyc8 = 0, cyc16 = 0;
    int unsigned     blk8 = 0, blk16 = 0;
    int unsigned     bc8 = 0, bc16 = 0;
    int unsigned     nd8 = 0, nd16 = 0;
    logic [64:0]     last8 = '0, last16 = '0;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .carry(carry8)
    );

    serial_adder_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
        .busy(busy16), .done(done16), .sum(sum16), .carry(carry16)
    );

    function automatic void chk(string name, logic [64:0] act, logic [64:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference: an accepted request occupies the block for W+2 edges and yields a+b+cin
    // on the done pulse observed W edges after acceptance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q8.delete();
            blk8 = 0;
        end else begin
            cyc8++;
            if (blk8 > 0) blk8--;
            else if (start8) begin
                exp_t e;
                e.val = 65'(a8) + 65'(b8) + 65'(cin8);
                e.due = cyc8 + 8;
                q8.push_back(e);
                last8 = e.val;
                blk8  = 9;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q16.delete();
            blk16 = 0;
        end else begin
            cyc16++;
            if (blk16 > 0) blk16--;
            else if (start16) begin
                exp_t e;
                e.val = 65'(a16) + 65'(b16) + 65'(cin16);
                e.due = cyc16 + 16;
                q16.push_back(e);
                last16 = e.val;
                blk16  = 17;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) bc8 = 0;
        else begin
            if (busy8) bc8++;
            if (done8) begin
                nd8++;
                chk("done8_expected", 65'(q8.size() != 0), 65'(1));
                if (q8.size() != 0) begin
                    exp_t e;
                    e = q8.pop_front();
                    chk("result8", {56'(0), carry8, sum8}, e.val);
                    chk("latency8", 65'(cyc8), 65'(e.due));
                    chk("busy_len8", 65'(bc8), 65'(8));
                    chk("busy_done_excl8", 65'(busy8), 65'(0));
                end
                bc8 = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) bc16 = 0;
        else begin
            if (busy16) bc16++;
            if (done16) begin
                nd16++;
                chk("done16_expected", 65'(q16.size() != 0), 65'(1));
                if (q16.size() != 0) begin
                    exp_t e;
                    e = q16.pop_front();
                    chk("result16", {48'(0), carry16, sum16}, e.val);
                    chk("latency16", 65'(cyc16), 65'(e.due));
                    chk("busy_len16", 65'(bc16), 65'(16));
                    chk("busy_done_excl16", 65'(busy16), 65'(0));
                end
                bc16 = 0;
            end
        end
    end

    task automatic op(input bit wide, input logic [15:0] a, input logic [15:0] b, input logic c);
        @(negedge clk);
        if (wide) begin a16 = a; b16 = b; cin16 = c; start16 = 1'b1; end
        else begin a8 = a[7:0]; b8 = b[7:0]; cin8 = c; start8 = 1'b1; end
        @(negedge clk);
        // Operands are scrambled after the accepting edge; the result must not depend on them.
        if (wide) begin start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); end
        else begin start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); end
    endtask

    task automatic drain(input bit wide, input bit check_hold);
        int unsigned n = 0;
        while ((wide ? q16.size() : q8.size()) != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (wide) begin
            chk("drain16_empty", 65'(q16.size()), 65'(0));
            q16.delete();
        end else begin
            chk("drain8_empty", 65'(q8.size()), 65'(0));
            q8.delete();
        end
        if (check_hold) begin
            repeat (2) @(negedge clk);
            if (wide) chk("hold16", {48'(0), carry16, sum16}, last16);
            else      chk("hold8", {56'(0), carry8, sum8}, last8);
        end
    endtask

    task automatic check_zero8(input string name);
        chk({name, "_busy"},  65'(busy8),  65'(0));
        chk({name, "_done"},  65'(done8),  65'(0));
        chk({name, "_sum"},   65'(sum8),   65'(0));
        chk({name, "_carry"}, 65'(carry8), 65'(0));
    endtask

    initial begin
        int unsigned d0;
        logic [15:0] corner_a[6] = '{16'h0000, 16'hFFFF, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000};
        logic [15:0] corner_b[6] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h0001, 16'h7FFF, 16'hFFFF};
        logic        corner_c[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        repeat (2) @(negedge clk);
        check_zero8("reset8");
        chk("reset16_busy", 65'(busy16), 65'(0));
        chk("reset16_out", {48'(0), carry16, sum16}, 65'(0));
        rst_n = 1'b1;

        op(1'b0, 16'h5A, 16'h3C, 1'b0); drain(1'b0, 1'b1);
        op(1'b0, 16'hFF, 16'h01, 1'b0); drain(1'b0, 1'b1);
        op(1'b0, 16'hFF, 16'hFF, 1'b1); drain(1'b0, 1'b1);

        // start held high for 40 edges: acceptances at the 1st, 11th, 21st and 31st
        d0 = nd8;
        @(negedge clk);
        start8 = 1'b1;
        repeat (40) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            @(negedge clk);
        end
        start8 = 1'b0;
        drain(1'b0, 1'b1);
        chk("held_start_count", 65'(nd8 - d0), 65'(4));

        // start pulsed while cnt==3 must be ignored
        d0 = nd8;
        op(1'b0, 16'h21, 16'h43, 1'b1);
        repeat (3) @(negedge clk);
        start8 = 1'b1; a8 = 8'h77; b8 = 8'h11;
        @(negedge clk);
        start8 = 1'b0;
        drain(1'b0, 1'b1);
        repeat (15) @(negedge clk);
        chk("ignored_start_count", 65'(nd8 - d0), 65'(1));

        // asynchronous abort at cnt==4
        op(1'b0, 16'hC3, 16'h5F, 1'b1);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero8("abort8");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_zero8("post_abort8");
        op(1'b0, 16'h10, 16'h20, 1'b0); drain(1'b0, 1'b1);

        repeat (40) begin
            op(1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
            drain(1'b0, 1'b0);
        end

        foreach (corner_a[i]) begin
            op(1'b1, corner_a[i], corner_b[i], corner_c[i]);
            drain(1'b1, 1'b1);
        end
        repeat (1000) begin
            op(1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
            drain(1'b1, 1'b0);
        end
        chk("w16_done_count", 65'(nd16), 65'(1006));

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2ms;
        fails++;
        $display("FAIL watchdog: simulation time limit reached, required completion before 2ms");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end
endmodule
